reset_supervisor: RTL and testbench

RESET_SUPERVISOR -- requirements
Module: reset_supervisor

---
 rtl/reset_supervisor.sv | 155 +++++++++++++++
 tb/tb_reset_supervisor.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/reset_supervisor.sv
// rtl/reset_supervisor.sv - button/watchdog reset sequencer with staggered per-channel release
// Optional watchdog compiled in with RESET_SUPERVISOR_WDT_EN.
module reset_supervisor #(
   parameter int          NUM_CHANNELS    = 3,
   parameter int          DEBOUNCE_CYCLES = 24000,
   parameter int          HOLD_CYCLES     = 16,
   parameter int          STAGGER_CYCLES  = 4,
   parameter logic [31:0] WDT_TIMEOUT     = 32'd24000000
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    button_n,
   input  logic                    wdt_enable,
   input  logic                    wdt_kick,
   output logic [NUM_CHANNELS-1:0] rst_out,
   output logic                    por_done,
   output logic [1:0]              reset_cause
);

   localparam int LAST_RELEASE = (NUM_CHANNELS - 1) * STAGGER_CYCLES;
   localparam int DEB_W  = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam int STAG_W = (LAST_RELEASE > 1) ? $clog2(LAST_RELEASE) : 1;

   localparam logic [1:0] CAUSE_POR    = 2'd0;
   localparam logic [1:0] CAUSE_BUTTON = 2'd1;
   localparam logic [1:0] CAUSE_WDT    = 2'd2;

   typedef enum logic [1:0] {
      ST_ASSERT,
      ST_HOLD,
      ST_RELEASE,
      ST_RUN
   } state_t;

   state_t            state, state_nxt;
   logic [1:0]        cause_nxt;
   logic [HOLD_W-1:0] hold_cnt;
   logic [STAG_W-1:0] stag_cnt;

   logic              sync_meta, sync_btn;
   logic [DEB_W-1:0]  deb_cnt;
   logic              deb_fired;
   logic              press;
   logic              wdt_fire;

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_meta <= 1'b1;
         sync_btn  <= 1'b1;
      end else begin
         sync_meta <= button_n;
         sync_btn  <= sync_meta;
      end
   end

   // The counter saturates once the low period is long enough; press is issued
   // one cycle later and deb_fired blocks repeats until a high sample is seen.
   always_ff @(posedge clk) begin
      if (reset) begin
         deb_cnt   <= '0;
         deb_fired <= 1'b0;
         press     <= 1'b0;
      end else begin
         press <= (deb_cnt == DEB_W'(DEBOUNCE_CYCLES)) && !deb_fired;
         if (sync_btn) begin
            deb_cnt   <= '0;
            deb_fired <= 1'b0;
         end else begin
            if (deb_cnt != DEB_W'(DEBOUNCE_CYCLES))
               deb_cnt <= deb_cnt + 1'b1;
            else
               deb_fired <= 1'b1;
         end
      end
   end

`ifdef RESET_SUPERVISOR_WDT_EN
   logic [31:0] wdt_cnt;

   assign wdt_fire = (state == ST_RUN) && wdt_enable && !wdt_kick &&
                     (wdt_cnt == WDT_TIMEOUT - 32'd1);

   always_ff @(posedge clk) begin
      if (reset || state != ST_RUN || !wdt_enable || wdt_kick || wdt_fire)
         wdt_cnt <= '0;
      else
         wdt_cnt <= wdt_cnt + 32'd1;
   end
`else
   logic unused_wdt;

   assign wdt_fire   = 1'b0;
   assign unused_wdt = wdt_enable ^ wdt_kick;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_ASSERT;
         reset_cause <= CAUSE_POR;
         hold_cnt    <= '0;
         stag_cnt    <= '0;
      end else begin
         state       <= state_nxt;
         reset_cause <= cause_nxt;
         if (state == ST_HOLD && state_nxt == ST_HOLD)
            hold_cnt <= hold_cnt + 1'b1;
         else
            hold_cnt <= '0;
         if (state == ST_RELEASE && state_nxt == ST_RELEASE)
            stag_cnt <= stag_cnt + 1'b1;
         else
            stag_cnt <= '0;
      end
   end

   always_comb begin
      state_nxt = state;
      cause_nxt = reset_cause;
      rst_out   = '0;
      por_done  = 1'b0;

      // Button outranks the watchdog when both land in the same cycle.
      if (press) begin
         state_nxt = ST_ASSERT;
         cause_nxt = CAUSE_BUTTON;
      end else if (wdt_fire) begin
         state_nxt = ST_ASSERT;
         cause_nxt = CAUSE_WDT;
      end else begin
         case (state)
            ST_ASSERT: state_nxt = ST_HOLD;
            ST_HOLD: begin
               if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1))
                  state_nxt = (LAST_RELEASE == 0) ? ST_RUN : ST_RELEASE;
            end
            ST_RELEASE: begin
               if (stag_cnt == STAG_W'(LAST_RELEASE - 1))
                  state_nxt = ST_RUN;
            end
            default: state_nxt = state;
         endcase
      end

      case (state)
         ST_ASSERT, ST_HOLD: rst_out = '1;
         ST_RELEASE: begin
            for (int i = 0; i < NUM_CHANNELS; i++)
               rst_out[i] = int'(stag_cnt) < i * STAGGER_CYCLES;
         end
         default: por_done = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_reset_supervisor.sv
// tb/tb_reset_supervisor.sv - scoreboard bench for reset_supervisor driven by a timeline model
`timescale 1ns/1ps
module tb_reset_supervisor;

   localparam int NC   = 3;
   localparam int DEB  = 4;
   localparam int HOLD = 2;
   localparam int STAG = 3;
   localparam int WDT  = 10;
   localparam int LAT  = 2 + DEB + 1;

   logic          clk        = 1'b0;
   logic          reset      = 1'b1;
   logic          button_n   = 1'b1;
   logic          wdt_enable = 1'b0;
   logic          wdt_kick   = 1'b0;
   logic [NC-1:0] rst_out;
   logic          por_done;
   logic [1:0]    reset_cause;

   reset_supervisor #(
      .NUM_CHANNELS   (NC),
      .DEBOUNCE_CYCLES(DEB),
      .HOLD_CYCLES    (HOLD),
      .STAGGER_CYCLES (STAG),
      .WDT_TIMEOUT    (32'd10)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .button_n   (button_n),
      .wdt_enable (wdt_enable),
      .wdt_kick   (wdt_kick),
      .rst_out    (rst_out),
      .por_done   (por_done),
      .reset_cause(reset_cause)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int            cyc;
      logic [NC-1:0] rst;
      logic          por;
      logic [1:0]    cause;
   } ev_t;

   ev_t exp_q[$];
   ev_t last_popped;
   int  model_run_at;
   int  model_assert_at;
   int  n_checks = 0;
   int  n_pass   = 0;

   task automatic push_ev(input int t, input logic [NC-1:0] r, input logic p, input logic [1:0] c);
      ev_t prev;
      ev_t e;
      prev = (exp_q.size() > 0) ? exp_q[exp_q.size()-1] : last_popped;
      if (prev.rst !== r || prev.por !== p || prev.cause !== c) begin
         e.cyc = t; e.rst = r; e.por = p; e.cause = c;
         exp_q.push_back(e);
      end
   endtask

   // Reset sequence whose all-ones phase becomes visible at cycle t; anything
   // the model had predicted from t onward is superseded.
   task automatic schedule(input int t, input logic [1:0] cause);
      logic [NC-1:0] m;
      while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc >= t)
         void'(exp_q.pop_back());
      push_ev(t, '1, 1'b0, cause);
      for (int i = 0; i < NC; i++) begin
         m = {NC{1'b1}} << (i + 1);
         push_ev(t + 1 + HOLD + i * STAG, m, (i == NC - 1), cause);
      end
      model_assert_at = t;
      model_run_at    = t + 1 + HOLD + (NC - 1) * STAG;
   endtask

   function automatic ev_t expected_at(input int c);
      ev_t e;
      e = last_popped;
      foreach (exp_q[k])
         if (exp_q[k].cyc <= c) e = exp_q[k];
      return e;
   endfunction

   task automatic wait_cyc(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic check_now(input string name);
      ev_t e;
      e = expected_at(cyc);
      n_checks++;
      if (rst_out === e.rst && por_done === e.por && reset_cause === e.cause)
         n_pass++;
      else
         $display("FAIL %s cyc=%0d got rst_out=%b por_done=%b cause=%0d want rst_out=%b por_done=%b cause=%0d",
                  name, cyc, rst_out, por_done, reset_cause, e.rst, e.por, e.cause);
   endtask

   // First low sample lands on the next posedge; the line is held low for len samples.
   task automatic low_pulse(input int len);
      int s;
      s = cyc + 1;
      if (len >= DEB) schedule(s + LAT, 2'd1);
      button_n = 1'b0;
      wait_cyc(s + len - 1);
      button_n = 1'b1;
   endtask

   task automatic kick_at(input int p);
      wait_cyc(p - 1);
      wdt_kick = 1'b1;
      wait_cyc(p);
      wdt_kick = 1'b0;
   endtask

   logic [NC+2:0] prev_obs = 'x;

   always @(negedge clk) begin
      ev_t e;
      if ({rst_out, por_done, reset_cause} !== prev_obs) begin
         prev_obs <= {rst_out, por_done, reset_cause};
         n_checks++;
         if (exp_q.size() == 0) begin
            $display("FAIL unexpected_change cyc=%0d got rst_out=%b por_done=%b cause=%0d want no change",
                     cyc, rst_out, por_done, reset_cause);
         end else begin
            e = exp_q.pop_front();
            last_popped = e;
            if (e.cyc == cyc && rst_out === e.rst && por_done === e.por && reset_cause === e.cause)
               n_pass++;
            else
               $display("FAIL event cyc=%0d got rst_out=%b por_done=%b cause=%0d want cyc=%0d rst_out=%b por_done=%b cause=%0d",
                        cyc, rst_out, por_done, reset_cause, e.cyc, e.rst, e.por, e.cause);
         end
      end
   end

   initial begin
      int c, len, gap, r;
      last_popped.cyc = 0; last_popped.rst = '0; last_popped.por = 1'b0; last_popped.cause = 2'd3;

      // Power-on: reset sampled on posedges 1 and 2.
      schedule(1, 2'd0);
      schedule(2, 2'd0);
      wait_cyc(2);
      reset = 1'b0;
      wait_cyc(model_run_at + 2);
      check_now("por_run");

      // Bounce: 3 low, 1 high, 3 low.
      low_pulse(3);
      wait_cyc(cyc + 1);
      low_pulse(3);
      wait_cyc(cyc + 10);
      check_now("bounce_idle");

      len = $urandom_range(4, 10);
      low_pulse(len);
      wait_cyc(model_run_at + 2);
      check_now("press_run");

      // Second press completes after channel 0 has released.
      low_pulse(4);
      c = model_assert_at + 1 + HOLD + $urandom_range(2, 5);
      wait_cyc(c - LAT - 1);
      low_pulse($urandom_range(4, 6));
      wait_cyc(c);
      check_now("release_repress");
      wait_cyc(model_run_at + 2);
      check_now("repress_run");

      repeat (10) begin
         gap = $urandom_range(1, 12);
         wait_cyc(cyc + gap);
         len = $urandom_range(1, 7);
         low_pulse(len);
      end
      wait_cyc(model_run_at + 3);
      check_now("random_settle");

`ifdef RESET_SUPERVISOR_WDT_EN
      low_pulse(4);
      wdt_enable = 1'b1;
      r = model_run_at;
      schedule(r + WDT, 2'd2);
      wait_cyc(r + WDT);
      check_now("wdt_fire");

      r = model_run_at;
      for (int k = 1; k <= 6; k++) kick_at(r + 9 * k);
      kick_at(r + 54 + WDT);
      schedule(r + 54 + 2 * WDT, 2'd2);
      wait_cyc(r + 54 + WDT + 2);
      check_now("kick_wins");
      wait_cyc(r + 54 + 2 * WDT);
      check_now("wdt_refire");

      r = model_run_at;
      wait_cyc(r + 2);
      low_pulse(5);
      wait_cyc(r + WDT);
      check_now("press_beats_wdt");
      wdt_enable = 1'b0;
      wait_cyc(model_run_at + 2);
`else
      wait_cyc(model_run_at + 1);
      wdt_enable = 1'b1;
      wait_cyc(cyc + 100);
      check_now("no_wdt");
      wdt_enable = 1'b0;
`endif

      // Reset in the middle of the release stagger.
      low_pulse(4);
      c = model_assert_at + 1 + HOLD + $urandom_range(0, (NC - 1) * STAG - 1);
      wait_cyc(c - 1);
      reset = 1'b1;
      schedule(c, 2'd0);
      schedule(c + 1, 2'd0);
      wait_cyc(c + 1);
      reset = 1'b0;
      check_now("mid_reset");
      wait_cyc(model_run_at + 2);
      check_now("reset_rerun");

      wait_cyc(cyc + 5);
      n_checks++;
      if (exp_q.size() == 0)
         n_pass++;
      else
         $display("FAIL drain pending=%0d want 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
